fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 103 ++++++++++
 tb/tb_fetch_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: one-entry instruction buffer, PC sequencing and
// branch redirect, with a drain state that retires an in-flight memory request.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc4
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        vld_q, vld_d;
  logic [31:0] tgt_q, tgt_d;
  logic        req;
  logic [31:0] br_tgt;

  // Low address bits are masked rather than dropped so the whole bus is used.
  assign br_tgt = branch_addr & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      vld_q   <= 1'b0;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      vld_q   <= vld_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    vld_d   = vld_q;
    tgt_d   = tgt_q;
    req     = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        req = !vld_q || !freeze;
        if (branch_taken) begin
          vld_d = 1'b0;
          // An unacknowledged request must be retired before moving the PC.
          if (req && !imem_ready) begin
            state_d = DRAIN;
            tgt_d   = br_tgt;
          end else begin
            pc_d = br_tgt;
          end
        end else if (req && imem_ready) begin
          instr_d = imem_rdata;
          pc4_d   = pc_q + 32'd4;
          vld_d   = 1'b1;
          pc_d    = pc_q + 32'd4;
        end else if (vld_q && !freeze) begin
          vld_d = 1'b0;
        end
      end
      DRAIN: begin
        req   = 1'b1;
        vld_d = 1'b0;
        if (branch_taken) tgt_d = br_tgt;
        if (imem_ready) begin
          pc_d    = branch_taken ? br_tgt : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr       = instr_q;
  assign instr_valid = vld_q;
  assign instr_pc4   = pc4_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios followed by randomized traffic, checked against a
// transaction-level model of the fetch front end.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze, branch_taken, imem_ready;
  logic [31:0] branch_addr, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc_out, instr, instr_pc4;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the PC, the buffered instruction, and a pending redirect
  // that is waiting for the in-flight memory response to come back.
  logic        m_started, m_v, m_pend;
  logic [31:0] m_pc, m_instr, m_pc4, m_tgt;

  fetch_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc_out(pc_out), .instr(instr),
    .instr_valid(instr_valid), .instr_pc4(instr_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_v = 1'b0; m_pend = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_tgt = 32'h0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc_out"}, pc_out, m_pc);
    chk({tag, ".instr_valid"}, {31'h0, instr_valid}, {31'h0, m_v});
    chk({tag, ".instr"}, instr, m_instr);
    chk({tag, ".instr_pc4"}, instr_pc4, m_pc4);
  endtask

  // Called at posedge+1; drives one cycle, checks, advances the model.
  task automatic step(input logic f, input logic b, input logic [31:0] ba, input logic r);
    logic        exp_req;
    logic [31:0] tgt;
    freeze = f; branch_taken = b; branch_addr = ba; imem_ready = r;
    imem_rdata = memf(m_pc);
    #3;
    exp_req = !m_started ? 1'b0 : (m_pend ? 1'b1 : (!m_v || !f));
    chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    check_regs("cyc");
    tgt = ba & 32'hFFFF_FFFC;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_pend) begin
      if (b) m_tgt = tgt;
      if (r) begin m_pc = m_tgt; m_pend = 1'b0; end
    end else if (b) begin
      m_v = 1'b0;
      if (exp_req && !r) begin m_pend = 1'b1; m_tgt = tgt; end
      else m_pc = tgt;
    end else if (exp_req && r) begin
      m_instr = memf(m_pc); m_pc4 = m_pc + 32'd4; m_v = 1'b1; m_pc = m_pc + 32'd4;
    end else if (m_v && !f) begin
      m_v = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs checked before any edge.
  task automatic do_reset();
    reset = 1'b0;
    freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; imem_ready = 1'b0;
    #1;
    model_reset();
    chk("rst.imem_req", {31'h0, imem_req}, 32'h0);
    check_regs("rst");
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    reset = 1'b1;
    #1 do_reset();

    // Straight-line fetch with memory always ready
    step(0, 0, 0, 1);                 // IDLE
    chk("idle.pc", pc_out, 32'h0);
    step(0, 0, 0, 1);                 // fetch 0
    chk("f0.valid", {31'h0, instr_valid}, 32'h1);
    chk("f0.pc4", instr_pc4, 32'h4);
    step(0, 0, 0, 1);                 // fetch 4
    chk("f4.pc", pc_out, 32'h8);
    // Freeze with a full buffer for three cycles
    repeat (3) step(1, 0, 0, 1);
    chk("frz.pc", pc_out, 32'h8);
    chk("frz.instr", instr, memf(32'h4));
    // Redirect while the fetch of 8 is outstanding
    step(0, 1, 32'h100, 0);
    chk("drain.pc", pc_out, 32'h8);
    chk("drain.valid", {31'h0, instr_valid}, 32'h0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("drain.done", pc_out, 32'h100);
    // Two redirects during a drain: newest wins
    step(0, 1, 32'h100, 0);
    step(0, 1, 32'h200, 0);
    step(0, 0, 0, 1);
    chk("drain2.pc", pc_out, 32'h200);
    // Unaligned target, PC wrap, alignment of 0x103
    step(0, 1, 32'hFFFF_FFFF, 1);
    chk("align.pc", pc_out, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap.pc", pc_out, 32'h0);
    chk("wrap.pc4", instr_pc4, 32'h0);
    step(0, 1, 32'h103, 1);
    chk("br103.pc", pc_out, 32'h100);
    // Reset while draining
    step(0, 1, 32'h40, 0);
    do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst.resume", pc_out, 32'h4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                $urandom, $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
